ps2_tx: RTL
===========

# ps2_tx

PS/2 host-to-device transmitter: the opposite direction of the `keyboard` receiver. It sends one command byte, such as `0xED` (set LEDs) or `0xFF` (reset), from the CPU to the keyboard. The block drives the shared `ps2c`/`ps2d` lines open-drain, performing the bus inhibit, request-to-send, data/parity/stop shifting and ACK check. It sits beside `keyboard` in `top`. A CPU write to `12'h902` pulses `wr` with `data_out[7:0]`, and a CPU read of `12'h903` returns `{13'b0, err_flag, done_flag, busy}`.

## Interface
- `INHIBIT_CYCLES`, default 5000: clocks the clock line is held low before request (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 100000: maximum clocks allowed between device clock falling edges after request (2 ms).
- `clk` in 1: system clock; all logic on posedge.
- `rst_n` in 1: synchronous, active-low reset.
- `wr` in 1: start a transmission; sampled only in IDLE.
- `din` in 8: command byte, captured when `wr` is accepted.
- `ps2c_in` in 1: pad level of the PS/2 clock.
- `ps2d_in` in 1: pad level of the PS/2 data.
- `ps2c_oe` out 1: 1 pulls the clock pad low; 0 releases it (high-Z).
- `ps2d_oe` out 1: 1 pulls the data pad low; 0 releases it.
- `busy` out 1: high from acceptance until `done`.
- `done` out 1: one-cycle pulse at end of transfer.
- `err` out 1: valid only with `done`; 1 means NACK or timeout.
- `rx_inhibit` out 1: equals `busy`; gates the `keyboard` receiver so it does not decode host-driven bits.

## Operation
- Inputs pass through a 2-FF synchronizer. `fall` is asserted when the previous synchronized clock is 1 and the current one is 0.
- Frame: an implicit start bit 0, then `din[0..7]` LSB first, then odd parity (`~^din`), then stop (release = 1), then the device ACK.
- IDLE:
  - All outputs are 0.
  - On `wr`, latch `din` and compute parity into a 9-bit shift register, load the counter, and go to INHIBIT.
- INHIBIT:
  - `ps2c_oe`=1.
  - Count `INHIBIT_CYCLES`, then go to REQ.
- REQ:
  - `ps2d_oe`=1 (start bit) and `ps2c_oe`=0.
  - Bit count = 0, watchdog loaded.
  - Go to DATA.
- DATA:
  - On each `fall`, present the next shift-register bit: `ps2d_oe` = ~bit.
  - After 9 falls (8 data + parity), the 10th `fall` releases data (`ps2d_oe`=0, stop) and moves to ACK.
- ACK:
  - On the next `fall`, sample the synchronized data: 0 = ACK, 1 = NACK. Store it and go to WAIT_IDLE.
- WAIT_IDLE:
  - Wait until both synchronized lines are 1, then pulse `done` (with `err` as stored) and go to IDLE.
- Watchdog:
  - Reloaded on every `fall` in REQ, DATA, ACK and WAIT_IDLE.
  - On expiry, release both lines, pulse `done` with `err`=1, and go to IDLE.
- `wr` while `busy` is ignored; no queueing.
- Reset at any point:
  - All outputs go to 0 next edge and the lines are released.
  - State becomes IDLE and the shift register and counters are cleared.
  - No `done` is produced for the aborted byte.

## Timing
- Reset values: `ps2c_oe`=0, `ps2d_oe`=0, `busy`=0, `done`=0, `err`=0, `rx_inhibit`=0.
- Acceptance:
  - With `wr`=1 at edge N, `busy`=1 and `ps2c_oe`=1 after edge N.
  - `ps2c_oe` falls and `ps2d_oe` rises in the same cycle, exactly `INHIBIT_CYCLES` cycles later.
- A pad falling edge changes `ps2d_oe` 3 clocks later: 2 sync stages plus the edge register. This is well inside the ~40 µs device clock low phase.
- `done` is high for exactly one cycle. `busy` drops in the same cycle as `done`, and a new `wr` is accepted on the following edge.
- The counters are sized `$clog2` of their parameter. The watchdog counts down and expires at 0.

## Structure
- Package `ps2_pkg`:
  - `typedef enum logic [2:0] {IDLE, INHIBIT, REQ, DATA, ACK, WAIT_IDLE}`.
  - Frame constants (`DATA_BITS`=8, `FRAME_FALLS`=11).
  - Memory-map constants `PS2TX_DATA`=12'h902 and `PS2TX_STAT`=12'h903.
- Sub-module `ps2_sync_edge`: synchronizes clock and data and produces `fall`. It is shareable with `keyboard`.
- Tri-state pad logic stays in `top`: `assign ps2c = ps2c_oe ? 1'b0 : 1'bz`, and the same for data.

## Test plan
- `wr` with `din`=0xED, device model clocking 11 falls and ACK low:
  - Line bits after start are 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - `done`=1, `err`=0.
- `din`=0x07: parity bit is 0. `din`=0x00: parity bit is 1. Both end with `done`, `err`=0.
- Device model holds data high at the ACK fall (NACK) -> `done`=1, `err`=1, both `oe` are 0 afterwards.
- Device never clocks after REQ -> after `TIMEOUT_CYCLES`, `done`=1 and `err`=1, and `ps2d_oe` is released.
- `wr` with `din`=0x55 pulsed mid-DATA of byte 0xFF -> ignored; only 0xFF appears on the line.
- `rst_n`=0 during bit 4 -> next edge all outputs are 0, no `done`; a following `wr` with 0xF4 completes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and its neighbours.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    DATA,
    ACK,
    WAIT_IDLE
  } ps2_state_e;

  localparam int DATA_BITS   = 8;
  localparam int FRAME_FALLS = 11;
  localparam int SHIFT_BITS  = DATA_BITS + 1;

  localparam logic [11:0] PS2TX_DATA = 12'h902;
  localparam logic [11:0] PS2TX_STAT = 12'h903;

  // Data bits LSB first followed by odd parity, ready to shift out of bit 0.
  function automatic logic [SHIFT_BITS-1:0] tx_frame(input logic [DATA_BITS-1:0] data);
    return {~^data, data};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-stage synchronizer for the PS/2 clock and data pads plus a clock falling-edge detector.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2c_in,
  input  logic ps2d_in,
  output logic c_sync,
  output logic d_sync,
  output logic fall
);

  logic [1:0] c_meta_q, c_meta_d;
  logic [1:0] d_meta_q, d_meta_d;
  logic       c_prev_q, c_prev_d;

  always_comb begin
    c_meta_d = {c_meta_q[0], ps2c_in};
    d_meta_d = {d_meta_q[0], ps2d_in};
    c_prev_d = c_meta_q[1];
  end

  // Reset to the idle bus level so no spurious edge is seen on release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_meta_q <= 2'b11;
      d_meta_q <= 2'b11;
      c_prev_q <= 1'b1;
    end else begin
      c_meta_q <= c_meta_d;
      d_meta_q <= d_meta_d;
      c_prev_q <= c_prev_d;
    end
  end

  assign c_sync = c_meta_q[1];
  assign d_sync = d_meta_q[1];
  assign fall   = c_prev_q & ~c_meta_q[1];

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, bit shifting and ACK check.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 ps2c_in,
  input  logic                 ps2d_in,
  output logic                 ps2c_oe,
  output logic                 ps2d_oe,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 rx_inhibit
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LOAD    = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LOAD     = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       RELEASE_CNT = 4'(FRAME_FALLS - 2);

  logic c_sync, d_sync, fall;

  ps2_sync_edge u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .ps2c_in (ps2c_in),
    .ps2d_in (ps2d_in),
    .c_sync  (c_sync),
    .d_sync  (d_sync),
    .fall    (fall)
  );

  ps2_state_e           state_q, state_d;
  logic [SHIFT_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0]     inh_cnt_q, inh_cnt_d;
  logic [WD_W-1:0]      wdog_q, wdog_d;
  logic                 nack_q, nack_d;
  logic                 ps2c_oe_q, ps2c_oe_d;
  logic                 ps2d_oe_q, ps2d_oe_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 expired;

  assign expired = !fall && (wdog_q == '0);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    wdog_d    = wdog_q;
    nack_d    = nack_q;
    ps2c_oe_d = ps2c_oe_q;
    ps2d_oe_d = ps2d_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    // Watchdog runs whenever the device is expected to be clocking.
    if (state_q == DATA || state_q == ACK || state_q == WAIT_IDLE) begin
      if (fall)
        wdog_d = WD_LOAD;
      else if (wdog_q != '0)
        wdog_d = wdog_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        ps2c_oe_d = 1'b0;
        ps2d_oe_d = 1'b0;
        if (wr) begin
          shift_d   = tx_frame(din);
          inh_cnt_d = INH_LOAD;
          bit_cnt_d = '0;
          nack_d    = 1'b0;
          ps2c_oe_d = 1'b1;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt_q == '0) begin
          ps2c_oe_d = 1'b0;
          ps2d_oe_d = 1'b1;
          wdog_d    = WD_LOAD;
          state_d   = REQ;
        end else begin
          inh_cnt_d = inh_cnt_q - 1'b1;
        end
      end
      REQ: begin
        bit_cnt_d = '0;
        wdog_d    = WD_LOAD;
        state_d   = DATA;
      end
      DATA: begin
        if (fall) begin
          if (bit_cnt_q == RELEASE_CNT) begin
            ps2d_oe_d = 1'b0;
            state_d   = ACK;
          end else begin
            ps2d_oe_d = ~shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (expired) begin
          ps2c_oe_d = 1'b0;
          ps2d_oe_d = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b1;
          state_d   = IDLE;
        end
      end
      ACK: begin
        if (fall) begin
          nack_d  = d_sync;
          state_d = WAIT_IDLE;
        end else if (expired) begin
          ps2c_oe_d = 1'b0;
          ps2d_oe_d = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b1;
          state_d   = IDLE;
        end
      end
      WAIT_IDLE: begin
        if (c_sync && d_sync) begin
          done_d  = 1'b1;
          err_d   = nack_q;
          state_d = IDLE;
        end else if (expired) begin
          ps2c_oe_d = 1'b0;
          ps2d_oe_d = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        ps2c_oe_d = 1'b0;
        ps2d_oe_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      wdog_q    <= '0;
      nack_q    <= 1'b0;
      ps2c_oe_q <= 1'b0;
      ps2d_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      wdog_q    <= wdog_d;
      nack_q    <= nack_d;
      ps2c_oe_q <= ps2c_oe_d;
      ps2d_oe_q <= ps2d_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign ps2c_oe    = ps2c_oe_q;
  assign ps2d_oe    = ps2d_oe_q;
  assign busy       = (state_q != IDLE);
  assign rx_inhibit = busy;
  assign done       = done_q;
  assign err        = err_q;

endmodule
